// File: rtl/fetch_queue_if.sv
// Instruction-memory bus between the fetch front end and instruction memory.
// Single outstanding request; responses come back in order, at least one cycle later.
interface fetch_queue_if;
    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch-stage front end: holds the fetch PC, issues one instruction request at a time,
// buffers returned words in a prefetch FIFO and drives the decode pipeline register.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           redirect_i,
    input  logic [31:0]    redirect_pc_i,
    input  logic           stall_d_i,
    input  logic           flush_d_i,
    fetch_queue_if.master  imem,
    output logic [31:0]    instr_d_o,
    output logic [31:0]    pc_plus_4_d_o,
    output logic           valid_d_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]        fifo_instr_q [DEPTH];
    logic [31:0]        fifo_pc4_q   [DEPTH];
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        pc_plus_4_q, pc_plus_4_d;
    logic               valid_q, valid_d;

    logic               redir;
    logic               push;
    logic               pop;
    logic               issue;
    logic [CNT_W-1:0]   count_after_push;

    // A stalled decode stage cannot act on a branch it resolved, so redirects wait for it.
    assign redir = redirect_i & ~stall_d_i;
    assign pop   = ~flush_d_i & ~stall_d_i & ~redir & (count_q != '0);
    assign count_after_push = count_q + CNT_W'(1) - CNT_W'(pop);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!redir && count_q < DEPTH_C) begin
                    issue   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem.rvalid) begin
                    if (redir) begin
                        state_d = IDLE;
                    end else begin
                        push = 1'b1;
                        if (count_after_push < DEPTH_C) begin
                            issue = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (redir) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem.rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // While a request is outstanding fetch_pc already points past it, so it is the response's PC+4.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redir) begin
            fetch_pc_d = redirect_pc_i;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        instr_d     = instr_q;
        pc_plus_4_d = pc_plus_4_q;
        valid_d     = valid_q;
        if (flush_d_i) begin
            instr_d = '0;
            valid_d = 1'b0;
        end else if (!stall_d_i) begin
            if (pop) begin
                instr_d     = fifo_instr_q[rd_ptr_q];
                pc_plus_4_d = fifo_pc4_q[rd_ptr_q];
                valid_d     = 1'b1;
            end else begin
                instr_d = '0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            instr_q     <= '0;
            pc_plus_4_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            instr_q     <= instr_d;
            pc_plus_4_q <= pc_plus_4_d;
            valid_q     <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push && !redir) begin
            fifo_instr_q[wr_ptr_q] <= imem.rdata;
            fifo_pc4_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    assign imem.req      = issue & ~rst_i;
    assign imem.addr     = rst_i ? RESET_PC : fetch_pc_q;
    assign instr_d_o     = instr_q;
    assign pc_plus_4_d_o = pc_plus_4_q;
    assign valid_d_o     = valid_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized redirects/stalls/flushes,
// checked cycle by cycle against a queue-based reference model and a variable-latency memory.
module tb_fetch_queue;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC2 = 32'hFFFF_FFF8;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] XOR_PAT   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_i, redirect_i, stall_d_i, flush_d_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_d_o, pc_plus_4_d_o;
    logic        valid_d_o;
    logic [31:0] instr2, pc4_2;
    logic        valid2;

    fetch_queue_if bus ();
    fetch_queue_if bus2 ();

    always #5 clk = ~clk;

    fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .stall_d_i(stall_d_i), .flush_d_i(flush_d_i), .imem(bus),
        .instr_d_o(instr_d_o), .pc_plus_4_d_o(pc_plus_4_d_o), .valid_d_o(valid_d_o)
    );

    fetch_queue #(.RESET_PC(RESET_PC2), .DEPTH(DEPTH)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .stall_d_i(1'b0), .flush_d_i(1'b0), .imem(bus2),
        .instr_d_o(instr2), .pc_plus_4_d_o(pc4_2), .valid_d_o(valid2)
    );

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    // Reference model state: fetch PC, outstanding/stale request, prefetch queue, decode register.
    logic [31:0] mFetchPc, mReqAddr, mInstr, mPc4;
    logic        mOut, mStale, mValid;
    logic [63:0] mQ[$];

    // Memory model state.
    logic        memBusy = 1'b0;
    int          memWait = 0;
    logic [31:0] memAddr = '0;
    int          memLatMin = 1, memLatMax = 1;
    logic        prevReq2 = 1'b0;
    logic [31:0] prevAddr2 = '0;
    logic        rec2 = 1'b0;
    logic [31:0] addr2Q[$];
    logic [31:0] pc2Q[$];
    logic        lastReq;
    logic [31:0] lastAddr;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cycle);
        end
    endtask

    task automatic applyStimulus(input logic rstIn, input logic redirIn, input logic [31:0] rpcIn,
                                 input logic stallIn, input logic flushIn);
        logic        expReq, redir, accept, done, pop, issue;
        logic [31:0] expAddr;
        logic [63:0] head;
        int          sizeAfter;
        @(negedge clk);
        rst_i         = rstIn;
        redirect_i    = redirIn;
        redirect_pc_i = rpcIn;
        stall_d_i     = stallIn;
        flush_d_i     = flushIn;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        if (memBusy) begin
            if (memWait == 0) begin
                bus.rvalid = 1'b1;
                bus.rdata  = memAddr ^ XOR_PAT;
                memBusy    = 1'b0;
            end else begin
                memWait--;
            end
        end
        bus2.rvalid = prevReq2;
        bus2.rdata  = prevAddr2 ^ XOR_PAT;
        #1;
        if (rstIn) begin
            expReq   = 1'b0;
            expAddr  = RESET_PC;
            mFetchPc = RESET_PC;
            mOut     = 1'b0;
            mStale   = 1'b0;
            mQ.delete();
            mInstr   = '0;
            mPc4     = '0;
            mValid   = 1'b0;
        end else begin
            redir     = redirIn & ~stallIn;
            accept    = bus.rvalid && mOut && !mStale && !redir;
            done      = bus.rvalid && mOut;
            pop       = !flushIn && !stallIn && !redir && (mQ.size() > 0);
            sizeAfter = mQ.size() - int'(pop) + int'(accept);
            if (!mOut)       issue = !redir && (mQ.size() < DEPTH);
            else if (mStale) issue = 1'b0;
            else             issue = accept && (sizeAfter < DEPTH);
            expReq  = issue;
            expAddr = mFetchPc;
            head = '0;
            if (pop) head = mQ.pop_front();
            if (redir) mQ.delete();
            else if (accept) mQ.push_back({mReqAddr + 32'd4, bus.rdata});
            if (flushIn) begin
                mInstr = '0;
                mValid = 1'b0;
            end else if (!stallIn) begin
                if (pop) begin
                    mInstr = head[31:0];
                    mPc4   = head[63:32];
                    mValid = 1'b1;
                end else begin
                    mInstr = '0;
                    mValid = 1'b0;
                end
            end
            if (redir) mFetchPc = rpcIn;
            else if (issue) begin
                mReqAddr = mFetchPc;
                mFetchPc = mFetchPc + 32'd4;
            end
            if (issue) begin
                mOut   = 1'b1;
                mStale = 1'b0;
            end else if (done) begin
                mOut   = 1'b0;
                mStale = 1'b0;
            end else if (redir && mOut) begin
                mStale = 1'b1;
            end
        end
        checkOutput("imem_req", 32'(bus.req), 32'(expReq));
        checkOutput("imem_addr", bus.addr, expAddr);
        lastReq  = bus.req;
        lastAddr = bus.addr;
        if (bus.req) begin
            memBusy = 1'b1;
            memWait = int'($urandom_range(memLatMax, memLatMin)) - 1;
            memAddr = bus.addr;
        end
        prevReq2  = bus2.req;
        prevAddr2 = bus2.addr;
        if (rec2 && bus2.req) addr2Q.push_back(bus2.addr);
        @(posedge clk);
        #1;
        checkOutput("valid_d", 32'(valid_d_o), 32'(mValid));
        checkOutput("instr_d", instr_d_o, mInstr);
        if (mValid) checkOutput("pc_plus_4_d", pc_plus_4_d_o, mPc4);
        if (rec2 && valid2) pc2Q.push_back(pc4_2);
        cycle++;
    endtask

    task automatic runNormal(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic waitForReq(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!found) begin
                applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
                if (lastReq) found = 1'b1;
            end
        end
        checkOutput(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int          firstReq, firstValid;
        logic        found;
        logic [31:0] exp2Addr[3];
        logic [31:0] exp2Pc[3];
        exp2Addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        exp2Pc   = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; stall_d_i = 1'b0; flush_d_i = 1'b0;
        bus.rvalid = 1'b0; bus.rdata = '0; bus2.rvalid = 1'b0; bus2.rdata = '0;

        // Reset, then back-to-back fetch with 1-cycle memory.
        rec2 = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        firstReq = -100;
        firstValid = -1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            if (firstReq < 0 && lastReq) firstReq = i;
            if (firstValid < 0 && valid_d_o) firstValid = i;
        end
        checkOutput("first_latency", 32'(firstValid - firstReq + 1), 32'd3);
        rec2 = 1'b0;
        checkOutput("dut2_req_count", 32'(addr2Q.size() >= 3), 32'd1);
        checkOutput("dut2_pc_count", 32'(pc2Q.size() >= 3), 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (i < addr2Q.size()) checkOutput("dut2_req_addr", addr2Q[i], exp2Addr[i]);
            if (i < pc2Q.size())   checkOutput("dut2_pc_plus_4", pc2Q[i], exp2Pc[i]);
        end

        // Long decode stall fills the FIFO, then drains on release.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        runNormal(10);

        // Redirect with a request outstanding to 3-cycle memory.
        memLatMin = 3; memLatMax = 3;
        waitForReq("pre_redirect_req");
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        waitForReq("redirect_req_seen");
        checkOutput("redirect_addr", lastAddr, 32'h0000_0100);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!found) begin
                applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
                if (valid_d_o) begin
                    found = 1'b1;
                    checkOutput("redirect_first_pc4", pc_plus_4_d_o, 32'h0000_0104);
                end
            end
        end
        checkOutput("redirect_valid_seen", 32'(found), 32'd1);

        // Redirect and flush while stalled.
        memLatMin = 1; memLatMax = 1;
        runNormal(6);
        applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        runNormal(6);

        // Reset while waiting; the old response arrives right after reset release.
        memLatMin = 3; memLatMax = 3;
        waitForReq("pre_reset_req");
        memLatMin = 1; memLatMax = 1;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("reset_first_req", 32'(lastReq), 32'd1);
        checkOutput("reset_first_addr", lastAddr, RESET_PC);
        runNormal(8);

        // Randomized traffic.
        memLatMin = 1; memLatMax = 3;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'b0,
                          ($urandom_range(99, 0) < 8),
                          ($urandom & 32'hFFFF_FFFC),
                          ($urandom_range(99, 0) < 20),
                          ($urandom_range(99, 0) < 8));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
